// File: rtl/mode_selector_pkg.sv
// Shared mode encodings, debounce FSM state type and the MODE stepping rule
// used by the two-button mode selector.
package mode_selector_pkg;

  localparam logic [1:0] MODE_ARITH   = 2'd0;
  localparam logic [1:0] MODE_LOGIC   = 2'd1;
  localparam logic [1:0] MODE_COMPARE = 2'd2;
  localparam logic [1:0] MODE_MAGIC   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  // press[0] steps forward, press[1] steps back; simultaneous presses cancel.
  function automatic logic [1:0] mode_next(input logic [1:0] mode,
                                           input logic [1:0] press);
    logic [1:0] result;
    result = mode;
    case (press)
      2'b01:   result = mode + 2'd1;
      2'b10:   result = mode - 2'd1;
      default: result = mode;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mode_selector_key_debounce.sv
// Single push-button conditioner: synchronizer, press/release debounce FSM,
// one-cycle press pulse and debounced held level.
module key_debounce
  import mode_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press,
  output logic pressed
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  db_state_t              state;
  logic [CNT_W-1:0]       cnt;

  // Reset to 1 so a key held through reset is seen as a fresh falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
    end else begin
      sync[0] <= key;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  assign synced = sync[SYNC_STAGES-1];

  // Decoded from state so the consumer registers the step on the same edge
  // that the FSM enters HELD.
  assign press = (state == PRESS_WAIT) && !synced && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!synced) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (synced) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state   <= HELD;
            pressed <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (synced) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!synced) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mode_selector.sv
// Two-button mode selector: KEY[0] steps MODE up, KEY[1] steps it down,
// with all outputs taken straight from flip-flops.
module mode_selector
  import mode_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] KEY,
  output logic [1:0] MODE,
  output logic       MODE_CHANGED,
  output logic [1:0] KEY_PRESSED
);

  logic [1:0] press;
  logic [1:0] mode_prev;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_key0 (
    .clk    (CLK),
    .rst    (RST),
    .key    (KEY[0]),
    .press  (press[0]),
    .pressed(KEY_PRESSED[0])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_key1 (
    .clk    (CLK),
    .rst    (RST),
    .key    (KEY[1]),
    .press  (press[1]),
    .pressed(KEY_PRESSED[1])
  );

  // MODE_CHANGED compares against the previous MODE, so it lands one cycle
  // after the update and cancelled double presses never raise it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MODE         <= MODE_ARITH;
      mode_prev    <= MODE_ARITH;
      MODE_CHANGED <= 1'b0;
    end else begin
      MODE         <= mode_next(MODE, press);
      mode_prev    <= MODE;
      MODE_CHANGED <= (MODE != mode_prev);
    end
  end

endmodule

// File: doc/mode_selector.md
MODE_SELECTOR -- requirements
Module: mode_selector

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning stable-sample count required to accept a key transition (10 ms at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of each KEY input synchronizer.
REQ-003 SHALL have port CLK  input  1  board clock (50 MHz); the only clock.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port KEY  input  2  raw push-buttons, active-low (0 = pressed), asynchronous to CLK.
REQ-006 SHALL have port MODE  output  2  selected mode: 0 arithmetic, 1 logical, 2 comparison, 3 magic.
REQ-007 SHALL have port MODE_CHANGED  output  1  one-cycle pulse in the cycle after MODE takes a new value.
REQ-008 SHALL have port KEY_PRESSED  output  2  debounced level per key, active-high (1 = held).

Function
REQ-009 SHALL pass each KEY bit through SYNC_STAGES flip-flops before any other logic uses it.
REQ-010 SHALL run one independent 4-state FSM per key: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-011 IDLE: synced key 0 -> PRESS_WAIT and clear counter; otherwise stay.
REQ-012 PRESS_WAIT: synced key 1 -> IDLE (bounce rejected, no pulse); when counter reaches DEBOUNCE_CYCLES-1 with key still 0 -> HELD and emit a one-cycle press pulse; otherwise increment counter.
REQ-013 HELD: synced key 1 -> RELEASE_WAIT and clear counter; otherwise stay (no repeat pulses).
REQ-014 RELEASE_WAIT: synced key 0 -> HELD (no new pulse); counter reaching DEBOUNCE_CYCLES-1 with key 1 -> IDLE.
REQ-015 KEY_PRESSED[i] SHALL be 1 in HELD and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-016 KEY[0] press pulse SHALL increment MODE modulo 4 (3 -> 0).
REQ-017 KEY[1] press pulse SHALL decrement MODE modulo 4 (0 -> 3).
REQ-018 Both press pulses in the same cycle SHALL leave MODE unchanged and SHALL NOT pulse MODE_CHANGED.
REQ-019 Latency from KEY falling edge (clean) to MODE update SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 CLK edges; MODE_CHANGED asserts one cycle later for one cycle.
REQ-020 Bounce shorter than DEBOUNCE_CYCLES consecutive stable samples SHALL produce no MODE change.
REQ-021 Counter width SHALL be clog2(DEBOUNCE_CYCLES)+1 bits and SHALL never wrap.
REQ-022 MODE, MODE_CHANGED, KEY_PRESSED SHALL be driven directly from flip-flops (glitch-free for HEX5/mux select).

Reset
REQ-023 RST high SHALL immediately force: synchronizer flops 1 (released), FSMs IDLE, counters 0, MODE 0, MODE_CHANGED 0, KEY_PRESSED 0.
REQ-024 A key held through RST deassertion SHALL be treated as a new press (IDLE -> PRESS_WAIT) and produce exactly one MODE step after full debounce.
REQ-025 RST asserted mid-debounce SHALL discard the pending press with no MODE change.

Structure
REQ-026 Shared package SHALL hold mode encodings (MODE_ARITH=0, MODE_LOGIC=1, MODE_COMPARE=2, MODE_MAGIC=3) and the debounce FSM state typedef.
REQ-027 One sub-module key_debounce (synchronizer, FSM, counter, press pulse, level) SHALL be instantiated twice; mode_selector holds only the MODE register and change logic.

Verification (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-028 Reset, KEY=2'b11 held 20 cycles -> MODE=0, MODE_CHANGED never asserted, KEY_PRESSED=00.
REQ-029 KEY[0] clean press held 10 cycles, 4 times -> MODE 1,2,3,0; each update exactly 7 edges after press; one MODE_CHANGED pulse each.
REQ-030 From MODE=0, KEY[1] clean press -> MODE=3; KEY_PRESSED[1]=1 from same edge until 4 stable released samples after release.
REQ-031 KEY[0] toggled every 2 cycles for 20 cycles then released -> MODE unchanged, no MODE_CHANGED.
REQ-032 Both keys pressed on the same cycle, held 10 cycles -> MODE unchanged, KEY_PRESSED=11, no MODE_CHANGED.
REQ-033 KEY[0] pressed, RST pulsed 2 cycles into PRESS_WAIT, key kept held -> MODE=0 during reset, then MODE=1 exactly 7 edges after RST deassertion.
